spi_controller_regs: RTL
========================

// Module: spi_controller_regs
// PURPOSE
//  SPI controller (initiator) for the 8-bit config/status register-file SPI target used in our ALU designs.
//  It turns a simple valid/ready register request into one 16-bit SPI frame.
//  It returns the byte sampled on MISO as the response.
//  Used in the bench and in the on-chip loopback/self-test to drive the SPI target side.
// PARAMETERS
//  CLK_DIV     4   spi_clk half-period in clk cycles; legal >= 4, so the target's 2-stage synchronizers resolve edges
//  REG_WIDTH   8   data field width; fixed at 8 by the frame format
//  ADDR_WIDTH  3   register address width; <= 7
// PORTS
//  clk        in   1           system clock; the only clock
//  rst        in   1           synchronous, active-high reset
//  ena        in   1           0 = freeze all state and outputs (hold), 1 = run
//  mode       in   2           {cpol,cpha}; sampled only on request accept
//  req_valid  in   1           request present
//  req_ready  out  1           controller can accept; = (state==IDLE) & ena
//  req_write  in   1           1 = write, 0 = read
//  req_addr   in   ADDR_WIDTH  register address
//  req_wdata  in   REG_WIDTH   write data; ignored for reads, but still shifted out as given
//  rsp_valid  out  1           one-cycle pulse: frame complete
//  rsp_rdata  out  REG_WIDTH   last 8 MISO bits of the frame; held until the next rsp_valid
//  busy       out  1           1 from the cycle after accept until return to IDLE
//  spi_cs_n   out  1           chip select, active low
//  spi_clk    out  1           SPI clock
//  spi_mosi   out  1           controller -> target data
//  spi_miso   in   1           target -> controller data; asynchronous, passed through a 2-FF synchronizer inside
// BEHAVIOUR
//  Frame format
//   - 16 bits, MSB first: [15] = req_write, [14:8] = zero-extended req_addr, [7:0] = req_wdata.
//  Accept
//   - Request is accepted when req_valid & req_ready at a rising clk edge.
//   - On accept, the frame, mode and req_write are latched. Input changes after accept are ignored.
//  FSM: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE
//   - IDLE:  cs_n=1, spi_clk=CPOL.
//   - SETUP: CLK_DIV cycles with cs_n=0; bit 15 is on MOSI.
//   - SHIFT: 16 bit periods of 2*CLK_DIV cycles each (32*CLK_DIV cycles total).
//   - HOLD:  CLK_DIV cycles, cs_n=0, spi_clk=CPOL.
//   - GAP:   CLK_DIV cycles, cs_n=1.
//  Timing (accept at edge T)
//   - cs_n falls at T+1.
//   - cs_n rises and rsp_valid pulses at T+1+34*CLK_DIV.
//   - req_ready returns at T+1+35*CLK_DIV (T+141 for CLK_DIV=4).
//  Clock phase
//   - Each bit period drives a leading edge (away from CPOL) after CLK_DIV cycles, then a trailing edge after 2*CLK_DIV.
//   - CPHA=0: MOSI changes on trailing edges (first bit set in SETUP); MISO is sampled on leading edges.
//   - CPHA=1: MOSI changes on leading edges; MISO is sampled on trailing edges.
//   - Exactly 16 leading and 16 trailing edges per frame.
//   - The last trailing edge leaves spi_clk=CPOL before HOLD.
//   - MISO sampling uses the synchronized value. The sample point is delayed by 2 clk cycles after the edge to cover synchronizer latency.
//   - The rx shift register takes 16 samples; rsp_rdata = rx[7:0].
//  Signal registration
//   - All SPI outputs are registered (glitch-free).
//   - spi_mosi is 0 while cs_n=1.
//  ena = 0
//   - Counters, FSM and outputs hold. The frame stretches; no edges are lost or added.
//  Reset
//   - Values: state=IDLE, spi_cs_n=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_rdata=0, busy=0, latched mode=0.
//   - Reset mid-frame aborts: the next edge gives cs_n=1, spi_clk=0, and no rsp_valid is issued.
//  Back-to-back requests
//   - req_valid held high is accepted at the first IDLE cycle.
//   - Minimum cs_n high time between frames is CLK_DIV+1 cycles.
// TESTING
//  1. mode=0, write addr=2 data=0xA5:
//     MOSI bits on rising edges = 0x82A5; 16 rising edges; cs_n low 136 cycles; rsp_valid once at T+137.
//  2. mode=3, read addr=5, target model returns 0x3C in the data byte:
//     MOSI = 0x0500; spi_clk idles 1; MISO sampled on rising edges; rsp_rdata=0x3C.
//  3. Modes 1 and 2 with MISO=0xC4 (id register):
//     rsp_rdata=0xC4 in both; MOSI transitions occur only on the correct edge polarity.
//  4. Three requests with req_valid held high:
//     three frames; cs_n high >= 5 cycles between frames; req_ready low while busy.
//  5. ena=0 for 20 cycles mid-SHIFT:
//     all outputs frozen; frame completes 20 cycles late with identical bit content.
//  6. rst pulse at bit 7 of a frame:
//     next edge gives cs_n=1, spi_clk=0, no rsp_valid; a new request afterwards completes normally.

Source files
------------

// File: rtl/spi_controller_regs.sv
// spi_controller_regs
// SPI initiator for the 8-bit config/status register-file target. A single
// valid/ready request becomes one 16-bit frame, MSB first:
//   [15] write flag, [14:8] zero-extended address, [7:0] write data.
// The last 8 bits sampled on MISO are returned as the response.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   ena             0 holds every register (frame stretches, no edges lost)
//   mode            {cpol, cpha}, latched when a request is accepted
//   req_*           request handshake and payload
//   rsp_valid/rdata one-cycle completion pulse and received byte (held)
//   busy            high from the cycle after accept until back in IDLE
//   spi_*           registered SPI pins; spi_miso is asynchronous
//
// State table
//   IDLE  | cs_n high, spi_clk parked at CPOL, waiting for a request
//   SETUP | cs_n low, bit 15 on MOSI, CLK_DIV cycles before the first edge
//   SHIFT | 32 half-periods of CLK_DIV cycles: leading edge, trailing edge
//   HOLD  | cs_n low, spi_clk at CPOL, lets the last MISO sample land
//   GAP   | cs_n high for CLK_DIV cycles, response issued on entry
module spi_controller_regs #(
    parameter int CLK_DIV    = 4,
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [1:0]            mode,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]  req_wdata,
    output logic                  rsp_valid,
    output logic [REG_WIDTH-1:0]  rsp_rdata,
    output logic                  busy,
    output logic                  spi_cs_n,
    output logic                  spi_clk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLK_DIV - 1);

    state_t               state_q, state_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [4:0]           half_q, half_nxt;
    logic [15:0]          tx_q, tx_nxt;
    logic [REG_WIDTH-1:0] rx_q, rx_nxt;
    logic [1:0]           mode_q, mode_nxt;
    logic [1:0]           samp_q, samp_nxt;
    logic                 miso_s1, miso_s2;
    logic                 cs_n_q, cs_n_nxt;
    logic                 sclk_q, sclk_nxt;
    logic                 mosi_q, mosi_nxt;
    logic                 rsp_valid_q, rsp_valid_nxt;
    logic [REG_WIDTH-1:0] rsp_rdata_q, rsp_rdata_nxt;
    logic                 busy_q;

    logic [6:0]  addr_ext;
    logic [15:0] frame;
    logic        accept;
    logic        cnt_tc;
    logic        cpol, cpha;

    always_comb begin
        addr_ext = '0;
        addr_ext[ADDR_WIDTH-1:0] = req_addr;
        frame = {req_write, addr_ext, req_wdata};
    end

    assign req_ready = (state_q == ST_IDLE) & ena;
    assign accept    = req_valid & req_ready;
    assign cnt_tc    = (cnt_q == '0);
    assign cpol      = mode_q[1];
    assign cpha      = mode_q[0];

    always_comb begin
        state_nxt     = state_q;
        cnt_nxt       = cnt_q;
        half_nxt      = half_q;
        tx_nxt        = tx_q;
        rx_nxt        = rx_q;
        mode_nxt      = mode_q;
        samp_nxt      = {samp_q[0], 1'b0};
        cs_n_nxt      = cs_n_q;
        sclk_nxt      = sclk_q;
        mosi_nxt      = mosi_q;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata_q;

        // The sample strobe trails its SPI edge by two cycles so the value
        // seen through the MISO synchronizer belongs to that edge.
        if (samp_q[1]) begin
            rx_nxt = {rx_q[REG_WIDTH-2:0], miso_s2};
        end

        if (state_q != ST_IDLE && !cnt_tc) begin
            cnt_nxt = cnt_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                cs_n_nxt = 1'b1;
                sclk_nxt = cpol;
                mosi_nxt = 1'b0;
                if (accept) begin
                    state_nxt = ST_SETUP;
                    cnt_nxt   = CNT_LOAD;
                    tx_nxt    = frame;
                    mode_nxt  = mode;
                    cs_n_nxt  = 1'b0;
                    sclk_nxt  = mode[1];
                    mosi_nxt  = frame[15];
                end
            end
            ST_SETUP: begin
                if (cnt_tc) begin
                    state_nxt = ST_SHIFT;
                    cnt_nxt   = CNT_LOAD;
                    half_nxt  = 5'd31;
                end
            end
            ST_SHIFT: begin
                if (cnt_tc) begin
                    cnt_nxt  = CNT_LOAD;
                    half_nxt = half_q - 5'd1;
                    // Odd half-counts end on a leading edge, even on trailing.
                    if (half_q[0]) begin
                        sclk_nxt    = ~cpol;
                        samp_nxt[0] = ~cpha;
                        if (cpha) begin
                            mosi_nxt = tx_q[15];
                            tx_nxt   = {tx_q[14:0], 1'b0};
                        end
                    end else begin
                        sclk_nxt    = cpol;
                        samp_nxt[0] = cpha;
                        // Bit 15 was presented in SETUP, so only 15 trailing
                        // edges move MOSI; the final one leaves bit 0 in place.
                        if (!cpha && half_q != 5'd0) begin
                            mosi_nxt = tx_q[14];
                            tx_nxt   = {tx_q[14:0], 1'b0};
                        end
                        if (half_q == 5'd0) begin
                            state_nxt = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_tc) begin
                    state_nxt     = ST_GAP;
                    cnt_nxt       = CNT_LOAD;
                    cs_n_nxt      = 1'b1;
                    mosi_nxt      = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    rsp_rdata_nxt = rx_q;
                end
            end
            ST_GAP: begin
                if (cnt_tc) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cs_n_nxt  = 1'b1;
                mosi_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            half_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            mode_q      <= 2'b00;
            samp_q      <= 2'b00;
            miso_s1     <= 1'b0;
            miso_s2     <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            half_q      <= half_nxt;
            tx_q        <= tx_nxt;
            rx_q        <= rx_nxt;
            mode_q      <= mode_nxt;
            samp_q      <= samp_nxt;
            miso_s1     <= spi_miso;
            miso_s2     <= miso_s1;
            cs_n_q      <= cs_n_nxt;
            sclk_q      <= sclk_nxt;
            mosi_q      <= mosi_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            busy_q      <= (state_nxt != ST_IDLE);
        end
    end

    assign spi_cs_n  = cs_n_q;
    assign spi_clk   = sclk_q;
    assign spi_mosi  = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;

endmodule
